reg_bank_writer: RTL and testbench

Write-back block that owns the eight 16-bit general registers and the R register, and drives them flattened to the operand mux that reads them. It accepts one write request at a time through a valid/ready handshake, selects the write data from ALU result, immediate, R, or memory, and commits it to a bank register or to R. Memory-sourced writes are multi-cycle, with a bounded wait and an error pulse on timeout.

---
 rtl/reg_bank_writer_pkg.sv | 22 ++
 rtl/reg_bank_writer.sv | 160 ++++++++++++++++
 tb/tb_reg_bank_writer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_writer_pkg.sv
// Shared definitions for the register write-back block:
// source-select encodings, FSM states and size defaults.
package reg_bank_writer_pkg;

   localparam int WIDTH_D   = 16;
   localparam int NREGS_D   = 8;
   localparam int TIMEOUT_D = 15;
   localparam int CNT_W     = 4;

   typedef enum logic [1:0] {
      SRC_ALU = 2'b00,
      SRC_IMM = 2'b01,
      SRC_R   = 2'b10,
      SRC_MEM = 2'b11
   } src_e;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MEMWAIT = 1'b1
   } state_e;

endpackage

// File: rtl/reg_bank_writer.sv
// Write-back stage: owns bank registers and R, commits one
// handshaked write at a time, memory writes wait for memValid.
module reg_bank_writer
   import reg_bank_writer_pkg::*;
#(
   parameter int WIDTH   = WIDTH_D,
   parameter int NREGS   = NREGS_D,
   parameter int TIMEOUT = TIMEOUT_D
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wrValid,
   output logic                   wrReady,
   input  logic [2:0]             wrDest,
   input  logic                   wrToR,
   input  logic [1:0]             srcSelect,
   input  logic [WIDTH-1:0]       aluData,
   input  logic [WIDTH-1:0]       imm,
   output logic                   memReq,
   input  logic                   memValid,
   input  logic [WIDTH-1:0]       memData,
   output logic [NREGS*WIDTH-1:0] regBank,
   output logic [WIDTH-1:0]       regR,
   output logic                   wbDone,
   output logic                   wbErr
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_dest;
   logic             r_toR;
   logic             r_memReq;
   logic             r_wbDone;
   logic             r_wbErr;
   logic [WIDTH-1:0] r_bank [NREGS];
   logic [WIDTH-1:0] r_R;

   logic             w_accept;
   logic             w_isMem;
   logic [WIDTH-1:0] w_srcData;
   logic             w_wrEn;
   logic             w_wrToR;
   logic [2:0]       w_wrIdx;
   logic [WIDTH-1:0] w_wrData;

   assign w_accept = (r_state == ST_IDLE) && wrValid;
   assign w_isMem  = (srcSelect == SRC_MEM);

   // Select the non-memory write source for a request in IDLE.
   always_comb begin
      w_srcData = '0;
      unique case (srcSelect)
         SRC_ALU: w_srcData = aluData;
         SRC_IMM: w_srcData = imm;
         SRC_R:   w_srcData = r_R;
         SRC_MEM: w_srcData = '0;
      endcase
   end

   // Decide whether a commit happens at this edge and what it writes.
   always_comb begin
      w_wrEn   = 1'b0;
      w_wrToR  = 1'b0;
      w_wrIdx  = '0;
      w_wrData = '0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept && !w_isMem) begin
               w_wrEn   = 1'b1;
               w_wrToR  = wrToR;
               w_wrIdx  = wrDest;
               w_wrData = w_srcData;
            end
         end
         ST_MEMWAIT: begin
            if (memValid) begin
               w_wrEn   = 1'b1;
               w_wrToR  = r_toR;
               w_wrIdx  = r_dest;
               w_wrData = memData;
            end
         end
      endcase
   end

   // Handshake FSM with wait counter and registered status pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_dest   <= '0;
         r_toR    <= 1'b0;
         r_memReq <= 1'b0;
         r_wbDone <= 1'b0;
         r_wbErr  <= 1'b0;
      end else begin
         r_wbDone <= w_wrEn;
         r_wbErr  <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_dest <= wrDest;
                  r_toR  <= wrToR;
                  if (w_isMem) begin
                     r_state  <= ST_MEMWAIT;
                     r_cnt    <= '0;
                     r_memReq <= 1'b1;
                  end
               end
            end
            ST_MEMWAIT: begin
               if (memValid) begin
                  r_state  <= ST_IDLE;
                  r_cnt    <= '0;
                  r_memReq <= 1'b0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state  <= ST_IDLE;
                  r_cnt    <= '0;
                  r_memReq <= 1'b0;
                  r_wbErr  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // Register storage: only the addressed target changes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            r_bank[i] <= '0;
         end
         r_R <= '0;
      end else if (w_wrEn) begin
         if (w_wrToR) begin
            r_R <= w_wrData;
         end else begin
            r_bank[w_wrIdx] <= w_wrData;
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < NREGS; g++) begin : g_flat
         assign regBank[WIDTH*g +: WIDTH] = r_bank[g];
      end
   endgenerate

   assign wrReady = (r_state == ST_IDLE);
   assign memReq  = r_memReq;
   assign regR    = r_R;
   assign wbDone  = r_wbDone;
   assign wbErr   = r_wbErr;

endmodule

// File: tb/tb_reg_bank_writer.sv
// Directed bench for reg_bank_writer: handshake writes,
// memory waits, timeout boundary and asynchronous reset.
module tb_reg_bank_writer;

   logic         clk;
   logic         reset;
   logic         wrValid;
   logic         wrReady;
   logic [2:0]   wrDest;
   logic         wrToR;
   logic [1:0]   srcSelect;
   logic [15:0]  aluData;
   logic [15:0]  imm;
   logic         memReq;
   logic         memValid;
   logic [15:0]  memData;
   logic [127:0] regBank;
   logic [15:0]  regR;
   logic         wbDone;
   logic         wbErr;

   int           n_cmp;
   int           n_err;
   logic [127:0] exp_bank;

   reg_bank_writer dut (
      .clk       (clk),
      .reset     (reset),
      .wrValid   (wrValid),
      .wrReady   (wrReady),
      .wrDest    (wrDest),
      .wrToR     (wrToR),
      .srcSelect (srcSelect),
      .aluData   (aluData),
      .imm       (imm),
      .memReq    (memReq),
      .memValid  (memValid),
      .memData   (memData),
      .regBank   (regBank),
      .regR      (regR),
      .wbDone    (wbDone),
      .wbErr     (wbErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      exp_bank  = '0;
      reset     = 1'b1;
      wrValid   = 1'b0;
      wrDest    = 3'd0;
      wrToR     = 1'b0;
      srcSelect = 2'b00;
      aluData   = 16'h0;
      imm       = 16'h0;
      memValid  = 1'b0;
      memData   = 16'h0;
      tick();
      tick();
      reset = 1'b0;
      tick();

      // reset state
      chk("rst_bank", regBank, exp_bank);
      chk("rst_R", 128'(regR), 128'h0);
      chk("rst_ready", 128'(wrReady), 128'h1);
      chk("rst_memReq", 128'(memReq), 128'h0);
      chk("rst_done", 128'(wbDone), 128'h0);
      chk("rst_err", 128'(wbErr), 128'h0);

      // immediate write to r5
      wrValid = 1'b1; wrDest = 3'd5; srcSelect = 2'b01; imm = 16'hBEEF;
      tick();
      wrValid = 1'b0;
      exp_bank[16*5 +: 16] = 16'hBEEF;
      chk("imm_bank", regBank, exp_bank);
      chk("imm_done", 128'(wbDone), 128'h1);
      tick();
      chk("imm_done_off", 128'(wbDone), 128'h0);

      // back-to-back ALU writes: r0, r7, then R
      wrValid = 1'b1; srcSelect = 2'b00; wrDest = 3'd0; aluData = 16'h0001;
      tick();
      exp_bank[16*0 +: 16] = 16'h0001;
      chk("b2b0_bank", regBank, exp_bank);
      chk("b2b0_done", 128'(wbDone), 128'h1);
      chk("b2b0_ready", 128'(wrReady), 128'h1);
      wrDest = 3'd7; aluData = 16'h0002;
      tick();
      exp_bank[16*7 +: 16] = 16'h0002;
      chk("b2b1_bank", regBank, exp_bank);
      chk("b2b1_done", 128'(wbDone), 128'h1);
      chk("b2b1_ready", 128'(wrReady), 128'h1);
      wrToR = 1'b1; wrDest = 3'd4; aluData = 16'h1234;
      tick();
      chk("b2b2_R", 128'(regR), 128'h1234);
      chk("b2b2_bank", regBank, exp_bank);
      chk("b2b2_done", 128'(wbDone), 128'h1);
      chk("b2b2_ready", 128'(wrReady), 128'h1);

      // R rewritten with itself, then R copied into r2
      srcSelect = 2'b10; aluData = 16'hDEAD;
      tick();
      chk("rself_R", 128'(regR), 128'h1234);
      chk("rself_done", 128'(wbDone), 128'h1);
      wrToR = 1'b0; wrDest = 3'd2;
      tick();
      wrValid = 1'b0;
      exp_bank[16*2 +: 16] = 16'h1234;
      chk("rcopy_bank", regBank, exp_bank);
      tick();
      chk("idle_done", 128'(wbDone), 128'h0);

      // memValid while idle has no effect
      memValid = 1'b1; memData = 16'hFFFF; wrDest = 3'd1;
      tick();
      memValid = 1'b0;
      chk("idlemem_bank", regBank, exp_bank);
      chk("idlemem_done", 128'(wbDone), 128'h0);

      // memory write to r3, data returned in the 4th wait cycle
      wrValid = 1'b1; wrDest = 3'd3; srcSelect = 2'b11;
      tick();
      wrValid = 1'b0; wrDest = 3'd0; srcSelect = 2'b00;
      chk("mem_done0", 128'(wbDone), 128'h0);
      repeat (3) begin
         chk("mem_req", 128'(memReq), 128'h1);
         chk("mem_ready", 128'(wrReady), 128'h0);
         tick();
      end
      chk("mem_req4", 128'(memReq), 128'h1);
      chk("mem_bank_wait", regBank, exp_bank);
      memValid = 1'b1; memData = 16'hA5A5;
      tick();
      memValid = 1'b0;
      exp_bank[16*3 +: 16] = 16'hA5A5;
      chk("mem_bank", regBank, exp_bank);
      chk("mem_done", 128'(wbDone), 128'h1);
      chk("mem_ready_back", 128'(wrReady), 128'h1);
      chk("mem_req_off", 128'(memReq), 128'h0);
      chk("mem_err", 128'(wbErr), 128'h0);

      // timeout: no memValid for 15 wait cycles
      wrValid = 1'b1; wrDest = 3'd6; srcSelect = 2'b11;
      tick();
      wrValid = 1'b0;
      repeat (14) tick();
      chk("to_req15", 128'(memReq), 128'h1);
      chk("to_err_early", 128'(wbErr), 128'h0);
      tick();
      chk("to_err", 128'(wbErr), 128'h1);
      chk("to_ready", 128'(wrReady), 128'h1);
      chk("to_req_off", 128'(memReq), 128'h0);
      chk("to_done", 128'(wbDone), 128'h0);
      chk("to_bank", regBank, exp_bank);
      tick();
      chk("to_err_off", 128'(wbErr), 128'h0);

      // memValid in the 15th wait cycle still writes
      wrValid = 1'b1; wrDest = 3'd6; srcSelect = 2'b11;
      tick();
      wrValid = 1'b0;
      repeat (14) tick();
      memValid = 1'b1; memData = 16'h5A5A;
      tick();
      memValid = 1'b0;
      exp_bank[16*6 +: 16] = 16'h5A5A;
      chk("edge_bank", regBank, exp_bank);
      chk("edge_done", 128'(wbDone), 128'h1);
      chk("edge_err", 128'(wbErr), 128'h0);

      // reset during the 2nd wait cycle, late memValid ignored
      wrValid = 1'b1; wrDest = 3'd1; srcSelect = 2'b11;
      tick();
      wrValid = 1'b0;
      tick();
      chk("rw_req", 128'(memReq), 128'h1);
      #2;
      reset = 1'b1;
      #1;
      exp_bank = '0;
      chk("rw_req_async", 128'(memReq), 128'h0);
      chk("rw_ready", 128'(wrReady), 128'h1);
      chk("rw_bank", regBank, exp_bank);
      chk("rw_R", 128'(regR), 128'h0);
      tick();
      reset = 1'b0;
      memValid = 1'b1; memData = 16'h7777;
      repeat (3) begin
         tick();
         chk("rw_late_done", 128'(wbDone), 128'h0);
         chk("rw_late_err", 128'(wbErr), 128'h0);
      end
      memValid = 1'b0;
      chk("rw_late_bank", regBank, exp_bank);
      chk("rw_late_req", 128'(memReq), 128'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
